// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: issues one imem request per accepted pc, arbitrates
// redirects, kills stale fetches and buffers one instruction for decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          KILL_CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pc_i,
  output logic                  pc_stall_o,
  output logic                  pc_redirect_valid_o,
  output logic [31:0]           pc_redirect_pc_o,
  input  logic                  trap_valid,
  input  logic [31:0]           trap_pc,
  input  logic                  ex_redirect_valid,
  input  logic [31:0]           ex_redirect_pc,
  input  logic                  id_redirect_valid,
  input  logic [31:0]           id_redirect_pc,
  output logic                  imem_req_valid,
  output logic [31:0]           imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [31:0]           imem_rsp_data,
  output logic                  if_valid,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_instr,
  input  logic                  if_ready,
  output logic [KILL_CNT_W-1:0] kill_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  drop_q, drop_d;
  logic [31:0]           req_pc_q, req_pc_d;
  logic [31:0]           if_pc_q, if_pc_d;
  logic [31:0]           if_instr_q, if_instr_d;
  logic [KILL_CNT_W-1:0] kill_q, kill_d;
  logic                  redir, accept, kill_inc;
  logic [31:0]           win_pc;

  always_comb begin
    redir = trap_valid | ex_redirect_valid | id_redirect_valid;
    if (trap_valid)             win_pc = trap_pc;
    else if (ex_redirect_valid) win_pc = ex_redirect_pc;
    else                        win_pc = id_redirect_pc;
    pc_redirect_valid_o = redir;
    pc_redirect_pc_o    = win_pc & 32'hFFFF_FFFC;
    // Never issue while redirecting: pc_i is about to be replaced.
    imem_req_valid = ~redir & ((state_q == S_FETCH) | ((state_q == S_HOLD) & if_ready));
    imem_req_addr  = pc_i;
    accept         = imem_req_valid & imem_req_ready;
    pc_stall_o     = ~accept;
    if_valid       = (state_q == S_HOLD) & ~redir;
    if_pc          = if_pc_q;
    if_instr       = if_instr_q;
    kill_cnt       = kill_q;
  end

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    req_pc_d   = accept ? pc_i : req_pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    kill_inc   = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (accept) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rsp_valid) begin
          if (drop_q | redir) begin
            // A response already marked stale counts once, even if re-redirected.
            kill_inc = 1'b1;
            drop_d   = 1'b0;
            state_d  = S_FETCH;
          end else begin
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rsp_data;
            state_d    = S_HOLD;
          end
        end else if (redir) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redir) begin
          kill_inc = 1'b1;
          state_d  = S_FETCH;
        end else if (if_ready) begin
          state_d = accept ? S_WAIT : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    kill_d = (kill_inc && !(&kill_q)) ? kill_q + {{(KILL_CNT_W-1){1'b0}}, 1'b1} : kill_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      drop_q     <= 1'b0;
      req_pc_q   <= RESET_VECTOR;
      if_pc_q    <= RESET_VECTOR;
      if_instr_q <= 32'h0;
      kill_q     <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      req_pc_q   <= req_pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      kill_q     <= kill_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: pc/imem environment, program-order reference model,
// redirect arbitration table, directed corner sequences and a random phase.
module tb_fetch_ctrl;
  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc_i;
  logic        pc_stall_o, pc_redirect_valid_o;
  logic [31:0] pc_redirect_pc_o;
  logic        trap_valid, ex_redirect_valid, id_redirect_valid;
  logic [31:0] trap_pc, ex_redirect_pc, id_redirect_pc;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic [15:0] kill_cnt;
  // Narrow-counter twin: sees identical stimulus, used for saturation.
  logic        s_stall, s_rv, s_req_v, s_if_valid;
  logic [31:0] s_rpc, s_req_addr, s_if_pc, s_if_instr;
  logic [3:0]  s_kill;

  fetch_ctrl #(.RESET_VECTOR(RV), .KILL_CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_stall_o(pc_stall_o),
    .pc_redirect_valid_o(pc_redirect_valid_o), .pc_redirect_pc_o(pc_redirect_pc_o),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
    .id_redirect_valid(id_redirect_valid), .id_redirect_pc(id_redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_pc(if_pc),
    .if_instr(if_instr), .if_ready(if_ready), .kill_cnt(kill_cnt));

  fetch_ctrl #(.RESET_VECTOR(RV), .KILL_CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .pc_i(pc_i), .pc_stall_o(s_stall),
    .pc_redirect_valid_o(s_rv), .pc_redirect_pc_o(s_rpc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .ex_redirect_valid(ex_redirect_valid), .ex_redirect_pc(ex_redirect_pc),
    .id_redirect_valid(id_redirect_valid), .id_redirect_pc(id_redirect_pc),
    .imem_req_valid(s_req_v), .imem_req_addr(s_req_addr),
    .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(s_if_valid), .if_pc(s_if_pc),
    .if_instr(s_if_instr), .if_ready(if_ready), .kill_cnt(s_kill));

  typedef struct {
    logic tv; logic [31:0] tp;
    logic ev; logic [31:0] ep;
    logic iv; logic [31:0] ip;
    logic xv; logic [31:0] xp;
  } rvec_t;

  int          checks = 0, failures = 0;
  logic [31:0] exp_pc;
  int          kills_m;
  logic        alive, last_acc, last_cons;
  logic [31:0] acc_q[$];
  int          rsp_lat, pend_cnt;
  logic        pend;
  logic [31:0] pend_addr;

  function automatic logic [31:0] instr(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] sat(input int k, input int mx);
    return (k > mx) ? 32'(mx) : 32'(k);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One clock: sample pre-edge, update reference model, then move pc and imem.
  task automatic step();
    logic        acc, cons, redir_m, rs, rv_s, st_s;
    logic [31:0] wpc, rpc_s, addr_s;
    @(posedge clk);
    rs      = rst;
    acc     = imem_req_valid & imem_req_ready;
    cons    = if_valid & if_ready;
    rv_s    = pc_redirect_valid_o;
    rpc_s   = pc_redirect_pc_o;
    st_s    = pc_stall_o;
    addr_s  = imem_req_addr;
    redir_m = trap_valid | ex_redirect_valid | id_redirect_valid;
    wpc = (trap_valid ? trap_pc : ex_redirect_valid ? ex_redirect_pc : id_redirect_pc)
          & 32'hFFFF_FFFC;
    last_acc  = acc;
    last_cons = cons;
    if (rs) begin
      exp_pc = RV; kills_m = 0; alive = 1'b0;
    end else begin
      chkb("redir_valid", rv_s, redir_m);
      chkb("redir_valid_s", s_rv, redir_m);
      if (redir_m) begin
        chk("redir_pc", rpc_s, wpc);
        chk("redir_pc_s", s_rpc, wpc);
        chkb("req_blocked", imem_req_valid, 1'b0);
        chkb("req_blocked_s", s_req_v, 1'b0);
      end
      chkb("stall", st_s, !acc);
      chkb("stall_s", s_stall, !acc);
      if (imem_req_valid) chk("req_addr", addr_s, pc_i);
      if (s_req_v) chk("req_addr_s", s_req_addr, pc_i);
      chkb("one_outstanding", acc && alive && !cons, 1'b0);
      if (cons) begin
        chk("if_pc", if_pc, exp_pc);
        chk("if_instr", if_instr, instr(exp_pc));
        chkb("if_valid_s", s_if_valid, 1'b1);
        chk("if_pc_s", s_if_pc, exp_pc);
        chk("if_instr_s", s_if_instr, instr(exp_pc));
        chk("kill_cnt", 32'(kill_cnt), sat(kills_m, 65535));
        chk("kill_cnt_s", 32'(s_kill), sat(kills_m, 15));
        exp_pc = exp_pc + 32'd4;
        alive  = 1'b0;
      end
      if (acc) begin
        alive = 1'b1;
        acc_q.push_back(addr_s);
      end
      if (redir_m) begin
        if (alive) kills_m++;
        alive  = 1'b0;
        exp_pc = wpc;
      end
    end
    #1;
    if (rs)        pc_i = RV;
    else if (rv_s) pc_i = rpc_s;
    else if (!st_s) pc_i = pc_i + 32'd4;
    imem_rsp_valid = 1'b0;
    if (acc) begin
      pend = 1'b1; pend_cnt = rsp_lat; pend_addr = addr_s;
    end
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr(pend_addr);
        pend = 1'b0;
      end
    end
  endtask

  task automatic clear_redir();
    trap_valid = 1'b0; ex_redirect_valid = 1'b0; id_redirect_valid = 1'b0;
  endtask

  // Step until FETCH with a pending request (req_valid without a buffered word).
  task automatic reach_fetch(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (imem_req_valid && !if_valid) found = 1'b1;
    end
    chkb(name, found, 1'b1);
  endtask

  task automatic reach_hold(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (if_valid) found = 1'b1;
    end
    chkb(name, found, 1'b1);
  endtask

  task automatic reach_accept(input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (last_acc) found = 1'b1;
    end
    chkb(name, found, 1'b1);
  endtask

  initial begin
    rvec_t       vecs [8];
    logic [31:0] p0;
    int          ncons;
    vecs[0] = '{1'b1, 32'h80,       1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h80};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h200, 1'b1, 32'h300, 1'b1, 32'h200};
    vecs[2] = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'h300};
    vecs[3] = '{1'b0, 32'h0,        1'b0, 32'h0,   1'b1, 32'h103, 1'b1, 32'h100};
    vecs[4] = '{1'b1, 32'h103,      1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'h100};
    vecs[5] = '{1'b0, 32'h0,        1'b1, 32'h202, 1'b0, 32'h0,   1'b1, 32'h200};
    vecs[6] = '{1'b1, 32'hFFFFFFFF, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'hFFFFFFFC};
    vecs[7] = '{1'b0, 32'h80,       1'b0, 32'h200, 1'b0, 32'h300, 1'b0, 32'h0};

    rst = 1'b1; pc_i = 32'h0; clear_redir();
    trap_pc = 32'h0; ex_redirect_pc = 32'h0; id_redirect_pc = 32'h0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    if_ready = 1'b1; rsp_lat = 1; pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0;
    exp_pc = RV; kills_m = 0; alive = 1'b0; last_acc = 1'b0; last_cons = 1'b0;

    // 1: reset state and basic streaming 0,4,8
    repeat (3) step();
    chkb("rst_req_valid", imem_req_valid, 1'b0);
    chkb("rst_if_valid", if_valid, 1'b0);
    chkb("rst_stall", pc_stall_o, 1'b1);
    chkb("rst_redir", pc_redirect_valid_o, 1'b0);
    chk("rst_kill", 32'(kill_cnt), 32'h0);
    chk("rst_if_pc", if_pc, RV);
    rst = 1'b0;
    acc_q.delete();
    for (int i = 0; i < 20 && acc_q.size() < 3; i++) step();
    chk("t1_n_acc", acc_q.size(), 3);
    if (acc_q.size() >= 3) begin
      chk("t1_addr0", acc_q[0], 32'h0);
      chk("t1_addr1", acc_q[1], 32'h4);
      chk("t1_addr2", acc_q[2], 32'h8);
    end

    // 2: request backpressure holds pc and address
    imem_req_ready = 1'b0;
    reach_fetch("t2_reach_fetch");
    p0 = pc_i;
    repeat (4) begin
      step();
      chkb("t2_req_valid", imem_req_valid, 1'b1);
      chk("t2_req_addr", imem_req_addr, p0);
      chk("t2_pc_held", pc_i, p0);
      chkb("t2_stall", pc_stall_o, 1'b1);
    end
    imem_req_ready = 1'b1;

    // 3: decode backpressure, then consume and request in one cycle
    if_ready = 1'b0;
    reach_hold("t3_reach_hold");
    repeat (3) begin
      step();
      chkb("t3_if_valid", if_valid, 1'b1);
      chkb("t3_no_req", imem_req_valid, 1'b0);
      chk("t3_if_pc", if_pc, exp_pc);
    end
    if_ready = 1'b1;
    #1;
    chkb("t3_req_now", imem_req_valid, 1'b1);
    step();
    chkb("t3_consumed", last_cons, 1'b1);
    chkb("t3_accepted", last_acc, 1'b1);

    // 4: EX redirect while waiting; stale response arrives two cycles later
    rsp_lat = 3;
    reach_accept("t4_reach_wait");
    ex_redirect_valid = 1'b1; ex_redirect_pc = 32'h100;
    step();
    clear_redir();
    chkb("t4_no_if_valid_a", if_valid, 1'b0);
    step();
    chkb("t4_no_if_valid_b", if_valid, 1'b0);
    step();
    chkb("t4_no_if_valid_c", if_valid, 1'b0);
    chk("t4_kill", 32'(kill_cnt), 32'h1);
    chkb("t4_req_valid", imem_req_valid, 1'b1);
    chk("t4_req_addr", imem_req_addr, 32'h100);
    rsp_lat = 1;
    repeat (6) step();

    // 5: redirect arbitration table, applied in FETCH with ready low
    imem_req_ready = 1'b0;
    reach_fetch("t5_reach_fetch");
    for (int i = 0; i < 8; i++) begin
      trap_valid = vecs[i].tv; trap_pc = vecs[i].tp;
      ex_redirect_valid = vecs[i].ev; ex_redirect_pc = vecs[i].ep;
      id_redirect_valid = vecs[i].iv; id_redirect_pc = vecs[i].ip;
      #1;
      chkb("t5_redir_valid", pc_redirect_valid_o, vecs[i].xv);
      if (vecs[i].xv) chk("t5_redir_pc", pc_redirect_pc_o, vecs[i].xp);
      chkb("t5_req_valid", imem_req_valid, !vecs[i].xv);
      chkb("t5_stall", pc_stall_o, 1'b1);
      clear_redir();
      step();
    end
    imem_req_ready = 1'b1;

    // 6a: kill saturation on the narrow twin
    if_ready = 1'b0;
    repeat (20) begin
      reach_hold("t6_reach_hold");
      trap_valid = 1'b1; trap_pc = 32'h40;
      step();
      clear_redir();
    end
    step();
    chk("t6_kill_sat", 32'(s_kill), 32'hF);
    chk("t6_kill_wide", 32'(kill_cnt), 32'd21);
    if_ready = 1'b1;

    // 6b: reset mid-WAIT; late response must be ignored
    rsp_lat = 4;
    reach_accept("t6_reach_wait");
    rst = 1'b1;
    step();
    rst = 1'b0; imem_req_ready = 1'b0;
    chkb("t6_rst_if_valid", if_valid, 1'b0);
    chk("t6_rst_kill", 32'(kill_cnt), 32'h0);
    chk("t6_rst_kill_s", 32'(s_kill), 32'h0);
    repeat (5) begin
      step();
      chkb("t6_ignore_rsp", if_valid, 1'b0);
    end
    imem_req_ready = 1'b1; rsp_lat = 1;
    repeat (6) step();

    // Random traffic against the reference model
    ncons = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      if_ready       = ($urandom_range(0, 3) != 0);
      rsp_lat        = $urandom_range(1, 3);
      r = $urandom_range(0, 99);
      trap_valid        = (r < 3);
      ex_redirect_valid = (r >= 3 && r < 7) || (r == 50);
      id_redirect_valid = (r >= 7 && r < 11) || (r == 50);
      trap_pc        = $urandom & 32'h0000_0FFF;
      ex_redirect_pc = $urandom & 32'h0000_0FFF;
      id_redirect_pc = $urandom & 32'h0000_0FFF;
      step();
      if (last_cons) ncons++;
    end
    clear_redir();
    imem_req_ready = 1'b1; if_ready = 1'b1;
    repeat (20) step();
    chkb("rand_progress", ncons > 100, 1'b1);
    chk("rand_kill", 32'(kill_cnt), sat(kills_m, 65535));
    chk("rand_kill_s", 32'(s_kill), sat(kills_m, 15));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
